aidc_lite_decomp_sr_mw: RTL and testbench



---
 rtl/aidc_lite_decomp_sr_mw_pkg.sv | 31 +++
 rtl/aidc_lite_decomp_sr_mw_if.sv | 30 +++
 rtl/aidc_lite_decomp_sr_mw_lane.sv | 24 ++
 rtl/aidc_lite_decomp_sr_mw.sv | 144 ++++++++++++++
 tb/tb_aidc_lite_decomp_sr_mw.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/aidc_lite_decomp_sr_mw_pkg.sv
// rtl/aidc_lite_decomp_sr_mw_pkg.sv - shared types and helpers for the multi-width SR decompressor
package aidc_lite_decomp_pkg;

   localparam int MAX_EW = 64;

   typedef enum logic {
      M8 = 1'b0,
      M4 = 1'b1
   } mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BODY = 2'd1,
      HALF = 2'd2
   } state_t;

   // The mode header lives in the MSB of the sop beat.
   function automatic int hdr_bit(input int in_w);
      return in_w - 1;
   endfunction

   function automatic logic [MAX_EW-1:0] sign_extend(input logic [MAX_EW-1:0] val,
                                                     input int src_w);
      logic [MAX_EW-1:0] mask;
      logic              sgn;
      mask = ~({MAX_EW{1'b1}} << src_w);
      sgn  = |(val & (mask ^ (mask >> 1)));
      return sgn ? (val | ~mask) : (val & mask);
   endfunction

endpackage

// File: rtl/aidc_lite_decomp_sr_mw_if.sv
// rtl/aidc_lite_decomp_sr_mw_if.sv - beat input / buffer write bundle of the SR decompressor
interface aidc_lite_decomp_sr_mw_if #(
   parameter int IN_W   = 32,
   parameter int EW     = 16,
   parameter int ADDR_W = 4
);
   localparam int OUT_W = (IN_W / 8) * EW;

   logic              valid_i;
   logic              ready_o;
   logic              sop_i;
   logic              eop_i;
   logic [IN_W-1:0]   data_i;
   logic              valid_o;
   logic [ADDR_W-1:0] addr_o;
   logic [OUT_W-1:0]  data_o;
   logic              done_o;
   logic              error_o;

   modport master (
      output valid_i, sop_i, eop_i, data_i,
      input  ready_o, valid_o, addr_o, data_o, done_o, error_o
   );

   modport slave (
      input  valid_i, sop_i, eop_i, data_i,
      output ready_o, valid_o, addr_o, data_o, done_o, error_o
   );

endinterface

// File: rtl/aidc_lite_decomp_sr_mw_lane.sv
// rtl/aidc_lite_decomp_sr_mw_lane.sv - combinational expansion of one beat/half-beat into one output word
module aidc_lite_decomp_sr_lane
   import aidc_lite_decomp_pkg::*;
#(
   parameter int IN_W = 32,
   parameter int EW   = 16
) (
   input  logic [IN_W-1:0]          src,
   input  logic                     m4,
   input  logic                     first_short,
   output logic [(IN_W/8)*EW-1:0]   word
);
   localparam int OUT_ELEMS = IN_W / 8;

   // In M4 only the low IN_W/2 bits of src carry elements.
   for (genvar k = 0; k < OUT_ELEMS; k++) begin : g_elem
      localparam bit IS_TOP = (k == OUT_ELEMS - 1);
      int src_w;
      assign src_w = (m4 ? 4 : 8) - ((IS_TOP && first_short) ? 1 : 0);
      assign word[EW*k +: EW] = EW'(sign_extend(m4 ? MAX_EW'(src[4*k +: 4])
                                                   : MAX_EW'(src[8*k +: 8]), src_w));
   end

endmodule

// File: rtl/aidc_lite_decomp_sr_mw.sv
// rtl/aidc_lite_decomp_sr_mw.sv - multi-width SR decompressor top; AIDC_DECOMP_SR_ERR_EN enables sticky error_o
module aidc_lite_decomp_sr_mw
   import aidc_lite_decomp_pkg::*;
#(
   parameter int IN_W   = 32,
   parameter int EW     = 16,
   parameter int ADDR_W = 4
) (
   input logic                     clk,
   input logic                     rst,
   aidc_lite_decomp_sr_mw_if.slave bus
);
   localparam int OUT_ELEMS = IN_W / 8;
   localparam int OUT_W     = OUT_ELEMS * EW;
   localparam int HALF_W    = IN_W / 2;
   localparam int HDR       = hdr_bit(IN_W);

   state_t            state_q, state_d;
   mode_t             mode_q, mode_d, beat_mode;
   logic [ADDR_W-1:0] addr_q, addr_d, wr_addr;
   logic [HALF_W-1:0] hold_q, hold_d;
   logic              hold_eop_q, hold_eop_d;
   logic              done_q, done_d;
   logic              valid_q;
   logic [ADDR_W-1:0] addr_out_q;
   logic [OUT_W-1:0]  data_q;
   logic              ready, accept, wr, final_word, lane_m4, lane_short;
   logic [IN_W-1:0]   lane_src;
   logic [OUT_W-1:0]  lane_word;

   assign ready     = (state_q != HALF);
   assign accept    = bus.valid_i & ready;
   assign beat_mode = bus.sop_i ? mode_t'(bus.data_i[HDR]) : mode_q;

   aidc_lite_decomp_sr_lane #(
      .IN_W (IN_W),
      .EW   (EW)
   ) u_lane (
      .src         (lane_src),
      .m4          (lane_m4),
      .first_short (lane_short),
      .word        (lane_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      addr_d     = addr_q;
      hold_d     = hold_q;
      hold_eop_d = hold_eop_q;
      done_d     = done_q;
      wr         = 1'b0;
      wr_addr    = addr_q;
      final_word = 1'b0;
      lane_src   = bus.data_i;
      lane_m4    = (beat_mode == M4);
      lane_short = bus.sop_i;
      case (state_q)
         IDLE, BODY: begin
            // A non-sop beat in IDLE is dropped without any write.
            if (accept && (state_q == BODY || bus.sop_i)) begin
               wr = 1'b1;
               if (bus.sop_i) begin
                  wr_addr = '0;
                  mode_d  = beat_mode;
                  done_d  = 1'b0;
               end
               if (beat_mode == M4) begin
                  lane_src   = {{HALF_W{1'b0}}, bus.data_i[IN_W-1:HALF_W]};
                  hold_d     = bus.data_i[HALF_W-1:0];
                  hold_eop_d = bus.eop_i;
                  state_d    = HALF;
               end else begin
                  final_word = bus.eop_i;
                  state_d    = bus.eop_i ? IDLE : BODY;
               end
            end
         end
         HALF: begin
            wr         = 1'b1;
            lane_src   = {{HALF_W{1'b0}}, hold_q};
            lane_m4    = 1'b1;
            lane_short = 1'b0;
            final_word = hold_eop_q;
            state_d    = hold_eop_q ? IDLE : BODY;
         end
         default: state_d = IDLE;
      endcase
      if (wr) begin
         addr_d = final_word ? '0 : wr_addr + ADDR_W'(1);
         if (final_word) done_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q     <= M8;
         addr_q     <= '0;
         hold_q     <= '0;
         hold_eop_q <= 1'b0;
         done_q     <= 1'b0;
         valid_q    <= 1'b0;
         addr_out_q <= '0;
         data_q     <= '0;
      end else begin
         mode_q     <= mode_d;
         addr_q     <= addr_d;
         hold_q     <= hold_d;
         hold_eop_q <= hold_eop_d;
         done_q     <= done_d;
         valid_q    <= wr;
         addr_out_q <= wr ? wr_addr : '0;
         data_q     <= wr ? lane_word : '0;
      end
   end

   assign bus.ready_o = ready;
   assign bus.valid_o = valid_q;
   assign bus.addr_o  = addr_out_q;
   assign bus.data_o  = data_q;
   assign bus.done_o  = done_q;

`ifdef AIDC_DECOMP_SR_ERR_EN
   logic err_q, err_set;
   // Wrap error: the counter would roll over on a word that does not end the packet.
   assign err_set = (accept && ((state_q == IDLE && !bus.sop_i) || (state_q == BODY && bus.sop_i)))
                 || (wr && !final_word && wr_addr == '1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
   end

   assign bus.error_o = err_q;
`else
   assign bus.error_o = 1'b0;
`endif

endmodule

// File: tb/tb_aidc_lite_decomp_sr_mw.sv
// tb/tb_aidc_lite_decomp_sr_mw.sv - directed self-checking bench for aidc_lite_decomp_sr_mw
module tb_aidc_lite_decomp_sr_mw;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   aidc_lite_decomp_sr_mw_if #(.IN_W(32), .EW(16), .ADDR_W(4)) bus ();

   aidc_lite_decomp_sr_mw #(.IN_W(32), .EW(16), .ADDR_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef AIDC_DECOMP_SR_ERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic [31:0] cont_beats [3] = '{32'h9ABC_1234, 32'h0F0F_7788, 32'hFFFF_0000};
   logic [63:0] cont_words [6] = '{64'h0001_FFFA_FFFB_FFFC, 64'h0001_0002_0003_0004,
                                   64'h0000_FFFF_0000_FFFF, 64'h0007_0007_FFF8_FFF8,
                                   64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic s, input logic e, input logic [31:0] d);
      bus.valid_i = v;
      bus.sop_i   = s;
      bus.eop_i   = e;
      bus.data_i  = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_valid"}, 64'(bus.valid_o), 64'd0);
      chk({tag, "_addr"},  64'(bus.addr_o),  64'd0);
      chk({tag, "_data"},  bus.data_o,       64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      tick();
      check_idle("rst");
      chk("rst_ready", 64'(bus.ready_o), 64'd1);
      chk("rst_done",  64'(bus.done_o),  64'd0);
      chk("rst_error", 64'(bus.error_o), 64'd0);
      rst = 1'b0;
      tick();

      // M8 two-beat packet
      drive(1'b1, 1'b1, 1'b0, 32'h7F80_01FF);
      tick();
      chk("m8_w0_valid", 64'(bus.valid_o), 64'd1);
      chk("m8_w0_addr",  64'(bus.addr_o),  64'd0);
      chk("m8_w0_data",  bus.data_o,       64'hFFFF_FF80_0001_FFFF);
      chk("m8_w0_done",  64'(bus.done_o),  64'd0);
      chk("m8_w0_ready", 64'(bus.ready_o), 64'd1);
      drive(1'b1, 1'b0, 1'b1, 32'h0000_0102);
      tick();
      chk("m8_w1_addr",  64'(bus.addr_o),  64'd1);
      chk("m8_w1_data",  bus.data_o,       64'h0000_0000_0001_0002);
      chk("m8_w1_done",  64'(bus.done_o),  64'd1);
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      check_idle("m8_idle");
      chk("m8_done_hold", 64'(bus.done_o), 64'd1);

      // M4 single-beat packet
      drive(1'b1, 1'b1, 1'b1, 32'h8765_4321);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      chk("m4_a_addr",  64'(bus.addr_o),  64'd0);
      chk("m4_a_data",  bus.data_o,       64'h0000_0007_0006_0005);
      chk("m4_a_ready", 64'(bus.ready_o), 64'd0);
      chk("m4_a_done",  64'(bus.done_o),  64'd0);
      tick();
      chk("m4_b_valid", 64'(bus.valid_o), 64'd1);
      chk("m4_b_addr",  64'(bus.addr_o),  64'd1);
      chk("m4_b_data",  bus.data_o,       64'h0004_0003_0002_0001);
      chk("m4_b_done",  64'(bus.done_o),  64'd1);
      chk("m4_b_ready", 64'(bus.ready_o), 64'd1);
      tick();
      check_idle("m4_idle");

      // M4 with valid_i held high; each beat is presented for two edges
      for (int c = 0; c < 6; c++) begin
         drive(1'b1, c < 2, c >= 4, cont_beats[c/2]);
         tick();
         chk("cont_valid", 64'(bus.valid_o), 64'd1);
         chk("cont_addr",  64'(bus.addr_o),  64'(c));
         chk("cont_data",  bus.data_o,       cont_words[c]);
         chk("cont_ready", 64'(bus.ready_o), 64'(c % 2));
         chk("cont_done",  64'(bus.done_o),  64'(c == 5));
      end
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      check_idle("cont_idle");
      chk("cont_error", 64'(bus.error_o), 64'd0);

      // 17 M8 beats: address wraps before eop
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, i == 0, i == 16, 32'(i));
         tick();
         chk("wrap_addr", 64'(bus.addr_o), 64'(i % 16));
         chk("wrap_data", bus.data_o,      64'(i));
         if (i == 14) chk("wrap_err_pre", 64'(bus.error_o), 64'd0);
      end
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      chk("wrap_done",  64'(bus.done_o),  64'd1);
      chk("wrap_error", 64'(bus.error_o), 64'(EXP_ERR));
      tick();
      check_idle("wrap_idle");

      // non-sop beat in IDLE is dropped
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 32'h0000_0055);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      check_idle("drop");
      chk("drop_error", 64'(bus.error_o), 64'(EXP_ERR));
      tick();
      check_idle("drop_after");

      // sop inside BODY restarts the packet
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 32'h0000_0011);
      tick();
      chk("rs_w0_data", bus.data_o, 64'h11);
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      check_idle("rs_gap");
      drive(1'b1, 1'b0, 1'b0, 32'h0000_0044);
      tick();
      chk("rs_w1_addr", 64'(bus.addr_o), 64'd1);
      chk("rs_w1_data", bus.data_o,      64'h44);
      chk("rs_pre_err", 64'(bus.error_o), 64'd0);
      drive(1'b1, 1'b1, 1'b0, 32'h0000_0022);
      tick();
      chk("rs_new_addr",  64'(bus.addr_o),  64'd0);
      chk("rs_new_data",  bus.data_o,       64'h22);
      chk("rs_new_done",  64'(bus.done_o),  64'd0);
      chk("rs_new_error", 64'(bus.error_o), 64'(EXP_ERR));
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      check_idle("rs_gap2");
      drive(1'b1, 1'b0, 1'b1, 32'h0000_0033);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      chk("rs_end_addr", 64'(bus.addr_o), 64'd1);
      chk("rs_end_data", bus.data_o,      64'h33);
      chk("rs_end_done", 64'(bus.done_o), 64'd1);

      // reset asserted while word B is pending
      drive(1'b1, 1'b1, 1'b0, 32'h8000_1111);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      chk("hr_a_valid", 64'(bus.valid_o), 64'd1);
      chk("hr_a_ready", 64'(bus.ready_o), 64'd0);
      rst = 1'b1;
      #1;
      check_idle("hr_async");
      chk("hr_async_ready", 64'(bus.ready_o), 64'd1);
      tick();
      check_idle("hr_next");
      chk("hr_next_ready", 64'(bus.ready_o), 64'd1);
      chk("hr_next_done",  64'(bus.done_o),  64'd0);
      chk("hr_next_error", 64'(bus.error_o), 64'd0);
      rst = 1'b0;
      tick();
      check_idle("hr_noB1");
      tick();
      check_idle("hr_noB2");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
